hazard_ctrl: RTL and testbench

- Drives the load/flush side of the pipeline registers: PC write enable, IF/ID load and flush, and the ID/EX bubble select that zeroes the 9-bit control word into ID/EX.
- Sequences the instruction-memory fetch handshake.
- Detects load-use hazards and branch-taken redirects; branches resolve in ID.
- Keeps saturating stall/flush counters and a sticky fetch-timeout error flag.

---
 rtl/pipe_ctrl_pkg.sv | 29 ++
 rtl/hazard_ctrl_sat_counter.sv | 26 ++
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/fetch control slice.
package pipe_ctrl_pkg;

    // Register-number width and the hardwired zero register.
    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // A load in EX whose destination is read by the instruction in ID.
    // Writes to the zero register never create a dependency.
    function automatic logic load_use(
        input logic             mem_read,
        input logic [REG_W-1:0] ex_rt,
        input logic [REG_W-1:0] id_rs,
        input logic [REG_W-1:0] id_rt,
        input logic             uses_rt
    );
        return mem_read && (ex_rt != ZERO_REG) &&
               ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: counts up on inc, holds at all-ones, clear wins.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] MAX = '1;
    localparam logic [W-1:0] ONE = W'(1);

    // Count register; stops at MAX instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc && (value != MAX)) begin
            value <= value + ONE;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and fetch control: PC/IF-ID load and flush, ID/EX bubble select,
// instruction-fetch handshake sequencing, statistics and fetch timeout.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             imem_ack,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             branch_taken,
    output logic             imem_req,
    output logic             imem_abort,
    output logic             pc_load,
    output logic             ifid_load,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             err
);

    // Wait counter must be able to hold TIMEOUT itself.
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              lu;
    logic              stall_inc;
    logic              flush_inc;
    logic              err_q;

    // Load-use hazard between the load in EX and the instruction in ID.
    always_comb begin
        lu = load_use(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);
    end

    // Next state and Mealy control outputs; priority is lu > branch > fetch.
    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        imem_req    = 1'b0;
        imem_abort  = 1'b0;
        pc_load     = 1'b0;
        ifid_load   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        case (state)
            S_IDLE: begin
                if (en) begin
                    state_nxt = S_RUN;
                end
            end

            S_RUN, S_WAIT: begin
                imem_req = 1'b1;
                if (lu) begin
                    // Freeze PC and IF/ID; any returning fetch is dropped and
                    // the same PC is fetched again. State and wait count hold.
                    idex_bubble = 1'b1;
                    stall_inc   = 1'b1;
                end else if (branch_taken) begin
                    // Redirect: load the target, squash the wrong-path slot.
                    // An unanswered fetch is cancelled this cycle only.
                    pc_load    = 1'b1;
                    ifid_flush = 1'b1;
                    imem_abort = !imem_ack;
                    flush_inc  = 1'b1;
                    wait_nxt   = '0;
                    state_nxt  = S_RUN;
                end else if (imem_ack) begin
                    pc_load   = 1'b1;
                    ifid_load = 1'b1;
                    wait_nxt  = '0;
                    state_nxt = S_RUN;
                end else begin
                    // No fetch data: hold PC, feed a bubble into IF/ID.
                    ifid_flush = 1'b1;
                    flush_inc  = 1'b1;
                    wait_nxt   = wait_cnt + WAIT_ONE;
                    state_nxt  = (wait_nxt == WAIT_LIMIT) ? S_ERR : S_WAIT;
                end
            end

            S_ERR: begin
                // Parked until reset; every control output stays low.
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and consecutive-miss counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Sticky timeout flag, raised on the same edge that enters ERR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (state_nxt == S_ERR) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .clear (1'b0),
        .value (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .clear (1'b0),
        .value (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised and directed bench for hazard_ctrl against a behavioural model.
module tb_hazard_ctrl;

    localparam int TO  = 4;
    localparam int CW  = 16;
    localparam int CWS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic en = 1'b0, imem_ack = 1'b0, id_uses_rt = 1'b0;
    logic ex_mem_read = 1'b0, branch_taken = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;

    logic imem_req, imem_abort, pc_load, ifid_load, ifid_flush, idex_bubble, err;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic imem_req_s, imem_abort_s, pc_load_s, ifid_load_s, ifid_flush_s, idex_bubble_s, err_s;
    logic [CWS-1:0] stall_cnt_s, flush_cnt_s;

    hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .imem_ack(imem_ack),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .imem_req(imem_req), .imem_abort(imem_abort), .pc_load(pc_load),
        .ifid_load(ifid_load), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .err(err)
    );

    hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CWS)) dut_s (
        .clk(clk), .rst(rst), .en(en), .imem_ack(imem_ack),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .imem_req(imem_req_s), .imem_abort(imem_abort_s), .pc_load(pc_load_s),
        .ifid_load(ifid_load_s), .ifid_flush(ifid_flush_s), .idex_bubble(idex_bubble_s),
        .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s), .err(err_s)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: idle / fetching / dead, plus a miss streak and
    // unbounded event tallies that are clipped per counter width on compare.
    int m_phase;   // 0 idle, 1 fetching, 2 dead
    int m_miss;
    int m_stall;
    int m_flush;

    function automatic int clip(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [31:0] ctrl_big();
        return 32'({imem_req, imem_abort, pc_load, ifid_load, ifid_flush, idex_bubble, err});
    endfunction

    function automatic logic [31:0] ctrl_small();
        return 32'({imem_req_s, imem_abort_s, pc_load_s, ifid_load_s, ifid_flush_s, idex_bubble_s, err_s});
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_miss  = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    // Check the present cycle against the model, then advance the model
    // as the coming rising edge will.
    task automatic eval_cycle();
        logic dep;
        logic e_req, e_abort, e_pc, e_load, e_flush, e_bub;
        logic [31:0] e_ctrl;
        dep = ex_mem_read && (ex_rt != 0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        {e_req, e_abort, e_pc, e_load, e_flush, e_bub} = '0;
        if (m_phase == 1) begin
            e_req = 1'b1;
            if (dep) begin
                e_bub = 1'b1;
            end else if (branch_taken) begin
                e_pc = 1'b1; e_flush = 1'b1; e_abort = !imem_ack;
            end else if (imem_ack) begin
                e_pc = 1'b1; e_load = 1'b1;
            end else begin
                e_flush = 1'b1;
            end
        end
        e_ctrl = 32'({e_req, e_abort, e_pc, e_load, e_flush, e_bub, (m_phase == 2)});
        chk("ctrl", ctrl_big(), e_ctrl);
        chk("ctrl_s", ctrl_small(), e_ctrl);
        chk("stall_cnt", 32'(stall_cnt), 32'(clip(m_stall, CW)));
        chk("flush_cnt", 32'(flush_cnt), 32'(clip(m_flush, CW)));
        chk("stall_cnt_s", 32'(stall_cnt_s), 32'(clip(m_stall, CWS)));
        chk("flush_cnt_s", 32'(flush_cnt_s), 32'(clip(m_flush, CWS)));
        chk("load_flush_excl", 32'(ifid_load & ifid_flush), 32'd0);

        if (m_phase == 0) begin
            if (en) m_phase = 1;
        end else if (m_phase == 1) begin
            if (dep) begin
                m_stall++;
            end else if (branch_taken) begin
                m_flush++;
                m_miss = 0;
            end else if (imem_ack) begin
                m_miss = 0;
            end else begin
                m_flush++;
                m_miss++;
                if (m_miss == TO) m_phase = 2;
            end
        end
    endtask

    task automatic apply(input logic i_en, input logic i_ack, input logic i_br,
                         input logic i_mr, input logic [4:0] i_exrt,
                         input logic [4:0] i_rs, input logic [4:0] i_rt,
                         input logic i_uses);
        @(negedge clk);
        en = i_en; imem_ack = i_ack; branch_taken = i_br;
        ex_mem_read = i_mr; ex_rt = i_exrt; id_rs = i_rs; id_rt = i_rt;
        id_uses_rt = i_uses;
        #1;
        eval_cycle();
    endtask

    // Plain fetch cycle with no hazard inputs.
    task automatic fetch(input logic i_ack);
        apply(1'b0, i_ack, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    // Asynchronous reset asserted wherever the caller currently is.
    task automatic do_reset(input string where);
        rst = 1'b0;
        #1;
        chk({where, "_ctrl"}, ctrl_big(), 32'd0);
        chk({where, "_ctrl_s"}, ctrl_small(), 32'd0);
        chk({where, "_cnt"}, 32'({stall_cnt, flush_cnt}), 32'd0);
        chk({where, "_cnt_s"}, 32'({stall_cnt_s, flush_cnt_s}), 32'd0);
        model_reset();
        @(negedge clk);
        en = 1'b0; imem_ack = 1'b0; branch_taken = 1'b0; ex_mem_read = 1'b0;
        ex_rt = '0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        do_reset("rst0");

        // Steady fetching with ack always high.
        apply(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            fetch(1'b1);
            chk("run_pc_load", 32'(pc_load), 32'd1);
            chk("run_ifid_load", 32'(ifid_load), 32'd1);
        end
        chk("run_counters", 32'(stall_cnt + flush_cnt), 32'd0);

        // Load-use on rs, then the zero-register case.
        apply(1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
        chk("lu_pc_load", 32'(pc_load), 32'd0);
        chk("lu_bubble", 32'(idex_bubble), 32'd1);
        fetch(1'b1);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        apply(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("r0_bubble", 32'(idex_bubble), 32'd0);
        chk("r0_pc_load", 32'(pc_load), 32'd1);
        // Load-use through rt only when rt is read.
        apply(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0);
        chk("rt_unused_bubble", 32'(idex_bubble), 32'd0);
        apply(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b1);
        chk("rt_used_bubble", 32'(idex_bubble), 32'd1);

        // Branch with and without fetch data.
        apply(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("br_ack_abort", 32'(imem_abort), 32'd0);
        chk("br_ack_flush", 32'(ifid_flush), 32'd1);
        fetch(1'b1);
        chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("br_noack_abort", 32'(imem_abort), 32'd1);
        fetch(1'b1);
        chk("br_abort_once", 32'(imem_abort), 32'd0);

        // Hazard and branch together: stall wins.
        apply(1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0);
        chk("lu_br_pc_load", 32'(pc_load), 32'd0);
        chk("lu_br_flush", 32'(ifid_flush), 32'd0);
        fetch(1'b1);
        chk("lu_br_flush_cnt", 32'(flush_cnt), 32'd2);

        // Fetch timeout.
        do_reset("rst1");
        apply(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < TO; i++) fetch(1'b0);
        for (int i = 0; i < 3; i++) begin
            fetch(1'b1);
            chk("to_err", 32'(err), 32'd1);
            chk("to_pc_load", 32'(pc_load), 32'd0);
        end
        chk("to_flush_cnt", 32'(flush_cnt), 32'(TO));

        // Stall counter saturation on the narrow instance.
        do_reset("rst2");
        apply(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
        fetch(1'b1);
        chk("sat_stall_s", 32'(stall_cnt_s), 32'd3);
        chk("sat_stall", 32'(stall_cnt), 32'd5);

        // Reset while waiting, during a pending abort.
        do_reset("rst3");
        apply(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        fetch(1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("wait_abort", 32'(imem_abort), 32'd1);
        do_reset("rst_wait");

        // Random episodes.
        for (int ep = 0; ep < 20; ep++) begin
            for (int c = 0; c < 60; c++) begin
                apply(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 6),
                      ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end
            do_reset("rst_rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
